dct16_odd_seq: RTL and testbench

Sequencer that time-multiplexes one shared shift-add multiplier unit (SAU) to compute the odd half of a 16-point DCT-II. The unit produces the eight constant products ±9, ±25, ±43, ±57, ±70, ±80, ±87 and ±90 of an 11-bit signed sample. The block accepts the eight odd-part butterfly differences serially, one per cycle. It feeds each one to the SAU, selects and signs the products per the 16-point odd coefficient matrix, and accumulates the eight odd outputs O[0..7]. It sits between the even/odd butterfly stage and the column transpose buffer of the 2-D DCT2 path.

---
 rtl/dct16_odd_seq.sv | 116 +++++++++++
 tb/tb_dct16_odd_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dct16_odd_seq.sv
// dct16_odd_seq: serial odd-half 16-point DCT-II.
// Eight butterfly differences d[0..7] arrive one per cycle. A single shift-add
// unit (SAU) forms all eight constant products of the current sample. Eight
// accumulators pick their product and sign from the odd coefficient matrix,
// using the column counter as the index. After the eighth sample the sums are
// latched into a single output register and held until downstream accepts them.
module dct16_odd_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [10:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [159:0]       out_data
);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  // Odd rows of the 16-point DCT-II (row k is output O[k] = DCT row 2k+1).
  localparam logic signed [7:0] C_TAB [8][8] = '{
    '{ 8'sd90,  8'sd87,  8'sd80,  8'sd70,  8'sd57,  8'sd43,  8'sd25,  8'sd9  },
    '{ 8'sd87,  8'sd57,  8'sd9,  -8'sd43, -8'sd80, -8'sd90, -8'sd70, -8'sd25 },
    '{ 8'sd80,  8'sd9,  -8'sd70, -8'sd87, -8'sd25,  8'sd57,  8'sd90,  8'sd43 },
    '{ 8'sd70, -8'sd43, -8'sd87,  8'sd9,   8'sd90,  8'sd25, -8'sd80, -8'sd57 },
    '{ 8'sd57, -8'sd80, -8'sd25,  8'sd90, -8'sd9,  -8'sd87,  8'sd43,  8'sd70 },
    '{ 8'sd43, -8'sd90,  8'sd57,  8'sd25, -8'sd87,  8'sd70,  8'sd9,  -8'sd80 },
    '{ 8'sd25, -8'sd70,  8'sd90, -8'sd80,  8'sd43,  8'sd9,  -8'sd57,  8'sd87 },
    '{ 8'sd9,  -8'sd25,  8'sd43, -8'sd57,  8'sd70, -8'sd80,  8'sd87, -8'sd90 }
  };

  state_t       state;
  logic [2:0]   cnt;
  logic [159:0] acc;
  logic [159:0] acc_next;

  // Shared shift-add unit. Largest product is 90 * 1024, so 20 bits is ample.
  logic signed [19:0] x;
  logic signed [19:0] p9, p25, p43, p57, p70, p80, p87, p90;

  assign x   = {{9{in_data[10]}}, in_data};
  assign p9  = (x <<< 3) + x;
  assign p25 = (x <<< 4) + (x <<< 3) + x;
  assign p43 = (x <<< 5) + (x <<< 3) + (x <<< 1) + x;
  assign p57 = (x <<< 6) - (x <<< 3) + x;
  assign p70 = (x <<< 6) + (x <<< 2) + (x <<< 1);
  assign p80 = (x <<< 6) + (x <<< 4);
  assign p87 = (x <<< 6) + (x <<< 4) + (x <<< 3) - x;
  assign p90 = (x <<< 6) + (x <<< 4) + (x <<< 3) + (x <<< 1);

  for (genvar k = 0; k < 8; k++) begin : g_row
    logic signed [7:0]  coef;
    logic        [7:0]  mag;
    logic signed [19:0] prod;
    logic signed [19:0] base;

    assign coef = C_TAB[k][cnt];
    assign mag  = coef[7] ? -coef : coef;

    // Route the SAU product matching |C[k][cnt]| to this row.
    always_comb begin
      prod = '0;
      case (mag)
        8'd9:    prod = p9;
        8'd25:   prod = p25;
        8'd43:   prod = p43;
        8'd57:   prod = p57;
        8'd70:   prod = p70;
        8'd80:   prod = p80;
        8'd87:   prod = p87;
        8'd90:   prod = p90;
        default: prod = '0;
      endcase
    end

    // Column 0 starts a fresh sum, so the stale accumulator is never seen.
    assign base = (cnt == 3'd0) ? 20'sd0 : $signed(acc[20*k +: 20]);
    assign acc_next[20*k +: 20] = coef[7] ? (base - prod) : (base + prod);
  end

  // Sequencer: accumulate eight samples, then present one result set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      cnt       <= 3'd0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              out_data  <= acc_next;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_dct16_odd_seq.sv
// Scoreboard bench for dct16_odd_seq: the driver pushes expected result sets,
// and an independent monitor pops and compares them at each output handshake.
module tb_dct16_odd_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [10:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [159:0] out_data;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ready_mode = 1;           // 0: hold low, 1: hold high, 2: random
  logic [159:0] exp_q[$];

  int C[8][8] = '{
    '{90, 87, 80, 70, 57, 43, 25, 9},
    '{87, 57, 9, -43, -80, -90, -70, -25},
    '{80, 9, -70, -87, -25, 57, 90, 43},
    '{70, -43, -87, 9, 90, 25, -80, -57},
    '{57, -80, -25, 90, -9, -87, 43, 70},
    '{43, -90, 57, 25, -87, 70, 9, -80},
    '{25, -70, 90, -80, 43, 9, -57, 87},
    '{9, -25, 43, -57, 70, -80, 87, -90}
  };

  dct16_odd_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic logic [159:0] pack8(input int v[8]);
    logic [159:0] r;
    int t;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      t = v[k];
      r[20*k +: 20] = t[19:0];
    end
    return r;
  endfunction

  // Reference: plain matrix-vector product O = C * d.
  function automatic logic [159:0] model(input int d[8]);
    int o[8];
    for (int k = 0; k < 8; k++) begin
      o[k] = 0;
      for (int n = 0; n < 8; n++) o[k] += C[k][n] * d[n];
    end
    return pack8(o);
  endfunction

  // out_ready generator, sole writer of out_ready.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare every accepted result set against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("block_expected", 160'(exp_q.size() != 0), 160'd1);
      if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic send(input int d[8], input int nsamp, input int bubble_pct);
    logic hs;
    for (int n = 0; n < nsamp; n++) begin
      while ($urandom_range(0, 99) < bubble_pct) begin
        in_valid = 1'b0;
        in_data  = 11'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = 11'(d[n]);
      hs = 1'b0;
      for (int t = 0; t < 2000 && !hs; t++) begin
        @(negedge clk);
        hs = in_ready && !rst;
        @(posedge clk); #1;
      end
      if (!hs) check("input_timeout", 160'(hs), 160'd1);
    end
    in_valid = 1'b0;
    in_data  = 11'($urandom);
  endtask

  task automatic run_block(input int d[8], input int bubble_pct);
    exp_q.push_back(model(d));
    send(d, 8, bubble_pct);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int d[8];
  int ones[8]  = '{1, 1, 1, 1, 1, 1, 1, 1};
  int ones_o[8] = '{461, -155, 97, -73, 59, -53, 47, -43};
  logic [159:0] hold;
  logic stable;
  logic seen;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 160'(in_ready), 160'd1);
    check("reset_out_valid", 160'(out_valid), 160'd0);
    check("reset_out_data", out_data, 160'd0);

    // All-ones, back to back, with exact latency and one-cycle valid.
    exp_q.push_back(pack8(ones_o));
    send(ones, 8, 0);
    check("latency_valid", 160'(out_valid), 160'd1);
    check("latency_in_ready", 160'(in_ready), 160'd0);
    @(posedge clk); #1;
    check("valid_one_cycle", 160'(out_valid), 160'd0);
    check("in_ready_return", 160'(in_ready), 160'd1);

    // Impulses at n = 0 and n = 7.
    d = '{1023, 0, 0, 0, 0, 0, 0, 0};
    run_block(d, 0);
    d = '{0, 0, 0, 0, 0, 0, 0, 1023};
    run_block(d, 0);

    // Extremes on rows 0 and 7.
    d = '{-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024};
    run_block(d, 0);
    d = '{1023, -1023, 1023, -1023, 1023, -1023, 1023, -1023};
    run_block(d, 0);

    // Same random block with and without bubbles.
    for (int n = 0; n < 8; n++) d[n] = $urandom_range(0, 2047) - 1024;
    run_block(d, 60);
    run_block(d, 0);

    // Backpressure: result must hold and no input may be consumed.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pack8(ones_o));
    send(ones, 8, 0);
    hold = out_data;
    stable = out_valid;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = 11'($urandom);
      @(negedge clk);
      stable = stable && (out_data == hold) && out_valid && !in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("backpressure_hold", 160'(stable), 160'd1);
    ready_mode = 1;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid && out_ready;
    end
    check("release_handshake", 160'(seen), 160'd1);
    @(posedge clk); #1;
    check("release_in_ready", 160'(in_ready), 160'd1);
    check("release_out_valid", 160'(out_valid), 160'd0);

    // Reset mid-block discards the partial sums.
    d = '{500, -300, 77, 1023, -1024, 0, 0, 0};
    send(d, 5, 0);
    pulse_rst();
    exp_q.push_back(pack8(ones_o));
    send(ones, 8, 0);
    @(posedge clk); #1;

    // Reset during OUT drops the pending result.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 8; n++) d[n] = $urandom_range(0, 2047) - 1024;
    send(d, 8, 0);
    check("out_before_rst", 160'(out_valid), 160'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_out_valid", 160'(out_valid), 160'd0);
    check("rst_in_out_ready", 160'(in_ready), 160'd1);
    rst = 1'b0;
    ready_mode = 1;

    // Random blocks under random bubbles and backpressure.
    ready_mode = 2;
    for (int b = 0; b < 1000; b++) begin
      for (int n = 0; n < 8; n++) d[n] = $urandom_range(0, 2047) - 1024;
      run_block(d, $urandom_range(0, 40));
    end

    for (int t = 0; t < 5000 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 160'(exp_q.size()), 160'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
